// File: rtl/pwm_duty_sweep_if.sv
// pwm_duty_sweep_if: control inputs and duty outputs of the duty-cycle sweep generator
interface pwm_duty_sweep_if #(
    parameter int WIDTH = 10
);
    logic             en;
    logic             tick;
    logic [WIDTH-1:0] step;
    logic             saw;
    logic [WIDTH-1:0] duty;
    logic             load;
    logic             at_top;
    modport master (output en, tick, step, saw, input duty, load, at_top);
    modport slave  (input en, tick, step, saw, output duty, load, at_top);
endinterface

// File: rtl/pwm_duty_sweep.sv
// pwm_duty_sweep: triangle/sawtooth duty sweep with dwell at the extremes, feeding pwm load/data
module pwm_duty_sweep #(
    parameter int WIDTH    = 10,
    parameter int MAX_DUTY = 999,
    parameter int HOLD     = 4
) (
    input logic            clk,
    input logic            rst,
    pwm_duty_sweep_if.slave bus
);
    localparam int CW = HOLD > 0 ? $clog2(HOLD + 1) : 1;
    localparam logic [WIDTH:0]   MAX_S  = (WIDTH + 1)'(MAX_DUTY);
    localparam logic [WIDTH-1:0] MAX_D  = WIDTH'(MAX_DUTY);
    localparam logic [CW-1:0]    HOLD_C = CW'(HOLD);

    typedef enum logic [2:0] {IDLE, RISE, TOP_HOLD, FALL, BOT_HOLD} state_t;

    state_t           state, next_state, rise_state, fall_state;
    logic [WIDTH-1:0] duty, next_duty, rise_duty, fall_duty;
    logic [WIDTH:0]   sum;
    logic [CW-1:0]    cnt, next_cnt;
    logic             load, ev, in_hold, hold_done;

    // The leaving event of a hold immediately performs the next phase's step,
    // so each dwell lasts exactly HOLD events with no duty change.
    assign ev         = bus.tick && bus.en;
    assign sum        = {1'b0, duty} + {1'b0, bus.step};
    assign rise_duty  = sum >= MAX_S ? MAX_D : sum[WIDTH-1:0];
    assign rise_state = sum >= MAX_S ? TOP_HOLD : RISE;
    assign fall_duty  = bus.step >= duty ? '0 : duty - bus.step;
    assign fall_state = bus.step >= duty ? BOT_HOLD : FALL;
    assign in_hold    = state == TOP_HOLD || state == BOT_HOLD;
    assign hold_done  = cnt == HOLD_C;

    // State, duty and dwell counter registers; load flags a changed duty
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            duty  <= '0;
            load  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            duty  <= next_duty;
            load  <= next_duty != duty;
            cnt   <= next_cnt;
        end
    end

    // Next state, next duty and dwell count, advanced only on enabled ticks
    always_comb begin
        next_state = state;
        next_duty  = duty;
        if (ev) begin
            case (state)
                IDLE:     next_state = RISE;
                RISE: begin
                    next_state = rise_state;
                    next_duty  = rise_duty;
                end
                TOP_HOLD: if (hold_done) begin
                    next_state = bus.saw ? BOT_HOLD : fall_state;
                    next_duty  = bus.saw ? '0 : fall_duty;
                end
                FALL: begin
                    next_state = fall_state;
                    next_duty  = fall_duty;
                end
                BOT_HOLD: if (hold_done) begin
                    next_state = rise_state;
                    next_duty  = rise_duty;
                end
                default:  next_state = IDLE;
            endcase
        end
        next_cnt = !ev ? cnt : (in_hold && next_state == state) ? cnt + 1'b1 : '0;
    end

    // Drive the bus outputs from the registered state
    always_comb begin
        bus.duty   = duty;
        bus.load   = load;
        bus.at_top = state == TOP_HOLD;
    end
endmodule
